traffic_sensor_conditioner: RTL and testbench
=============================================

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 Parameter DB_LEN, default 1_000_000: debounce length in clk cycles; legal range >= 1.
REQ-002 Parameter TICK_DIV, default 25_000_000: tick period in clk cycles; legal range >= 2.
REQ-003 Port clk  input  1: clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: reset, asynchronous, active-high.
REQ-005 Port raw_sa  input  1: unsynchronised street-A car sensor; may glitch.
REQ-006 Port raw_sb  input  1: unsynchronised street-B car sensor; may glitch.
REQ-007 Port sa  output  1: debounced street-A sensor, fed to the traffic light controller.
REQ-008 Port sb  output  1: debounced street-B sensor, fed to the traffic light controller.
REQ-009 Port tick  output  1: single-cycle enable pulse that paces the controller's state register.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-011 Each channel SHALL hold a stable value, a debounce counter of width $clog2(DB_LEN+1), and its synchronised sample.
REQ-012 Synchronised sample equal to stable value -> counter SHALL clear to 0 on the next edge.
REQ-013 Synchronised sample differs and counter < DB_LEN-1 -> counter SHALL increment by 1.
REQ-014 Synchronised sample differs and counter == DB_LEN-1 -> stable value SHALL take the sample and the counter SHALL clear, on that edge.
REQ-015 sa and sb SHALL be the registered stable values; no combinational path from raw_* to sa/sb.
REQ-016 A clean raw level change SHALL appear on sa/sb exactly at the (DB_LEN+2)th rising edge, counting the first edge that samples the new raw level; rising and falling edges have the same latency.
REQ-017 A synchronised pulse or gap shorter than DB_LEN cycles SHALL leave sa/sb unchanged; the counter restarts from 0 after every bounce back.
REQ-018 Channels A and B SHALL be fully independent; simultaneous changes on both SHALL be handled in parallel with identical latency.
REQ-019 The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-020 tick SHALL be registered and high for exactly one cycle per wrap.
REQ-021 The first tick SHALL be high during the TICK_DIV-th cycle after reset deasserts, then every TICK_DIV cycles.
REQ-022 The tick counter SHALL be free-running and SHALL ignore sensor activity.
REQ-023 Counters SHALL never exceed their terminal values; no overflow states are reachable.

Reset
REQ-024 While reset is high: sa=0, sb=0, tick=0, all synchroniser flops=0, all counters=0.
REQ-025 Reset asserted mid-debounce or mid-period SHALL discard partial counts immediately; counting restarts from 0 after release.
REQ-026 A raw input held high through reset release SHALL reach sa/sb with the full REQ-016 latency measured from the first post-reset edge.

Configuration
REQ-027 Macro TRAFFIC_TICK_GEN_EN defined: the tick generator per REQ-019..022 SHALL be compiled in.
REQ-028 Macro TRAFFIC_TICK_GEN_EN undefined: no tick counter SHALL exist; tick SHALL be 0 during reset and constant 1 otherwise, so the controller advances every clk; debounce is unaffected.

Structure
REQ-029 Shared package traffic_pkg SHALL hold the default DB_LEN and TICK_DIV constants and the light encoding constants GREEN=2'b00, YELLOW=2'b01, RED=2'b10 used by the controller.
REQ-030 Sub-module sensor_debounce (synchroniser + counter + stable register, parameter DB_LEN) SHALL be instantiated once per channel; the tick generator stays inline.

Verification (bench uses DB_LEN=4, TICK_DIV=5)
REQ-031 Reset release, raw_sa=raw_sb=0 -> sa=sb=0 throughout; tick high in cycles 5, 10, 15 after release and low elsewhere.
REQ-032 raw_sa rises before edge 0 and stays high -> sa=1 after edge 5; sa=0 before edge 5; sb stays 0.
REQ-033 raw_sb 1-0-1-0 bouncing in 2-cycle segments, then held high -> sb stays 0 during bouncing; sb=1 exactly 6 edges after the final rise.
REQ-034 Both raw inputs fall on the same edge from settled 1 -> sa and sb drop to 0 on the same edge, 6 edges later.
REQ-035 reset pulsed 2 cycles after raw_sa rises (mid-debounce) -> sa stays 0; after release sa=1 6 edges later; tick period restarts (first tick at cycle 5).
REQ-036 Build without TRAFFIC_TICK_GEN_EN -> tick=1 every cycle after reset release; REQ-032 result unchanged.

Source files
------------

// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared constants for the traffic light slice: default timing and light encodings.
package traffic_pkg;

    localparam int DB_LEN_DEFAULT   = 1_000_000;
    localparam int TICK_DIV_DEFAULT = 25_000_000;

    // Light encodings consumed by the downstream traffic light controller
    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs between the sensor front end and the controller.
interface traffic_sensor_conditioner_if;

    logic raw_sa;
    logic raw_sb;
    logic sa;
    logic sb;
    logic tick;

    modport master (output raw_sa, raw_sb, input sa, sb, tick);
    modport slave  (input raw_sa, raw_sb, output sa, sb, tick);

endinterface

// File: rtl/traffic_sensor_conditioner_sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and registered stable value.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DB_LEN = DB_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam int              CNT_W   = $clog2(DB_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LEN - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             sample;

    assign sample = sync_q[1];

    // The counter only advances while the sample disagrees with the stable value,
    // so any bounce back restarts the count from zero.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sample != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Debounces both street sensors and paces the controller with a tick enable.
// Define TRAFFIC_TICK_GEN_EN to build the divided tick; otherwise tick is high whenever out of reset.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DB_LEN   = DB_LEN_DEFAULT,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    traffic_sensor_conditioner_if.slave  bus
);

    if (DB_LEN < 1 || TICK_DIV < 2) begin : g_bad_param
        $error("traffic_sensor_conditioner: DB_LEN must be >= 1 and TICK_DIV >= 2");
    end

    sensor_debounce #(.DB_LEN(DB_LEN)) u_deb_a (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (bus.raw_sa),
        .stable_o (bus.sa)
    );

    sensor_debounce #(.DB_LEN(DB_LEN)) u_deb_b (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (bus.raw_sb),
        .stable_o (bus.sb)
    );

`ifdef TRAFFIC_TICK_GEN_EN
    localparam int               TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_q, tick_d;

    // Free-running divider; tick is registered on the wrap so it lands in the
    // TICK_DIV-th cycle after reset and repeats every TICK_DIV cycles.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
        tick_d     = 1'b0;
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.tick = tick_q;
`else
    assign bus.tick = ~reset;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed self-checking bench for traffic_sensor_conditioner with DB_LEN=4, TICK_DIV=5.
module tb_traffic_sensor_conditioner;

    localparam int DB_LEN   = 4;
    localparam int TICK_DIV = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    traffic_sensor_conditioner_if bus ();

    traffic_sensor_conditioner #(.DB_LEN(DB_LEN), .TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected tick value k edges after reset release
    function automatic logic expTick(input int k);
`ifdef TRAFFIC_TICK_GEN_EN
        return (k % TICK_DIV) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int holdEdges);
        reset = 1'b1;
        repeat (holdEdges) stepEdge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.raw_sa = 1'b0;
        bus.raw_sb = 1'b0;
        reset = 1'b1;
        repeat (3) stepEdge();
        checks += 3;
        if (bus.sa !== 1'b0) begin errors++; $display("[TB] FAIL reset_sa: got %b expected 0", bus.sa); end
        if (bus.sb !== 1'b0) begin errors++; $display("[TB] FAIL reset_sb: got %b expected 0", bus.sb); end
        if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b expected 0", bus.tick); end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            stepEdge();
            checks += 3;
            if (bus.sa !== 1'b0) begin errors++; $display("[TB] FAIL idle_sa_k%0d: got %b expected 0", k, bus.sa); end
            if (bus.sb !== 1'b0) begin errors++; $display("[TB] FAIL idle_sb_k%0d: got %b expected 0", k, bus.sb); end
            if (bus.tick !== expTick(k)) begin
                errors++;
                $display("[TB] FAIL idle_tick_k%0d: got %b expected %b", k, bus.tick, expTick(k));
            end
        end
    endtask

    task automatic test_sa_rise();
        bus.raw_sa = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            stepEdge();
            checks += 2;
            if (bus.sa !== (e >= 5)) begin
                errors++;
                $display("[TB] FAIL sa_rise_e%0d: got %b expected %b", e, bus.sa, (e >= 5));
            end
            if (bus.sb !== 1'b0) begin errors++; $display("[TB] FAIL sa_rise_sb_e%0d: got %b expected 0", e, bus.sb); end
        end
    endtask

    task automatic test_sb_bounce();
        logic [7:0] pattern;
        pattern = 8'b0011_0011;
        for (int i = 0; i < 8; i++) begin
            bus.raw_sb = pattern[i];
            stepEdge();
            checks += 2;
            if (bus.sb !== 1'b0) begin errors++; $display("[TB] FAIL bounce_sb_i%0d: got %b expected 0", i, bus.sb); end
            if (bus.sa !== 1'b1) begin errors++; $display("[TB] FAIL bounce_sa_i%0d: got %b expected 1", i, bus.sa); end
        end
        bus.raw_sb = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            stepEdge();
            checks++;
            if (bus.sb !== (e >= 5)) begin
                errors++;
                $display("[TB] FAIL bounce_settle_e%0d: got %b expected %b", e, bus.sb, (e >= 5));
            end
        end
    endtask

    task automatic test_both_fall();
        bus.raw_sa = 1'b0;
        bus.raw_sb = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            stepEdge();
            checks += 2;
            if (bus.sa !== (e < 5)) begin
                errors++;
                $display("[TB] FAIL fall_sa_e%0d: got %b expected %b", e, bus.sa, (e < 5));
            end
            if (bus.sb !== (e < 5)) begin
                errors++;
                $display("[TB] FAIL fall_sb_e%0d: got %b expected %b", e, bus.sb, (e < 5));
            end
        end
    endtask

    task automatic test_reset_mid(input int preEdges);
        bus.raw_sa = 1'b0;
        bus.raw_sb = 1'b0;
        applyReset(2);
        repeat (3) stepEdge();
        bus.raw_sa = 1'b1;
        repeat (preEdges) stepEdge();
        reset = 1'b1;
        #1;
        checks += 2;
        if (bus.sa !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_sa_p%0d: got %b expected 0", preEdges, bus.sa); end
        if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_tick_p%0d: got %b expected 0", preEdges, bus.tick); end
        repeat (2) stepEdge();
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            stepEdge();
            checks += 2;
            if (bus.sa !== (k >= 6)) begin
                errors++;
                $display("[TB] FAIL mid_sa_p%0d_k%0d: got %b expected %b", preEdges, k, bus.sa, (k >= 6));
            end
            if (bus.tick !== expTick(k)) begin
                errors++;
                $display("[TB] FAIL mid_tick_p%0d_k%0d: got %b expected %b", preEdges, k, bus.tick, expTick(k));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.raw_sa = 1'b0;
        bus.raw_sb = 1'b0;
        test_reset();
        test_sa_rise();
        test_sb_bounce();
        test_both_fall();
        test_reset_mid(2);
        test_reset_mid(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
